// File: rtl/resource_tag_track_bp.sv
// resource_tag_track_bp
//
// Sits in front of a shared compute resource that does not carry the ctl
// routing tag. The ctl of every accepted request packet goes into an in-order
// tag FIFO. The tag at the head of the FIFO is re-attached to every beat of
// the matching response packet. Request packets are blocked at sop when the
// FIFO is full, so the number of outstanding requests never exceeds the FIFO
// depth.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_req_*               request stream from the arbiter (sink)
//   o_req_*               request stream to the resource (source)
//   i_rsp_*               response stream from the resource (sink); ctl ignored
//   o_rsp_*               response stream with restored ctl, to the demux (source)
//   o_outstanding         current tag FIFO occupancy
//   o_timeout             sticky watchdog flag
//
// Build option
//   RESOURCE_TAG_TIMEOUT_EN  when defined, adds a watchdog that sets o_timeout
//                            after TIMEOUT_CYC cycles with tags outstanding and
//                            no pop. When undefined, o_timeout is tied to 0.

module resource_tag_track_bp #(
  parameter int CTL_BITS        = 16,
  parameter int DAT_BYTS        = 8,
  parameter int DAT_BITS        = DAT_BYTS * 8,
  parameter int MOD_BITS        = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1,
  parameter int MAX_OUTSTANDING = 8,
  parameter int TIMEOUT_CYC     = 1024
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst_n,

  input  logic                                     i_req_val,
  output logic                                     i_req_rdy,
  input  logic [DAT_BITS-1:0]                      i_req_dat,
  input  logic                                     i_req_sop,
  input  logic                                     i_req_eop,
  input  logic                                     i_req_err,
  input  logic [MOD_BITS-1:0]                      i_req_mod,
  input  logic [CTL_BITS-1:0]                      i_req_ctl,

  output logic                                     o_req_val,
  input  logic                                     o_req_rdy,
  output logic [DAT_BITS-1:0]                      o_req_dat,
  output logic                                     o_req_sop,
  output logic                                     o_req_eop,
  output logic                                     o_req_err,
  output logic [MOD_BITS-1:0]                      o_req_mod,
  output logic [CTL_BITS-1:0]                      o_req_ctl,

  input  logic                                     i_rsp_val,
  output logic                                     i_rsp_rdy,
  input  logic [DAT_BITS-1:0]                      i_rsp_dat,
  input  logic                                     i_rsp_sop,
  input  logic                                     i_rsp_eop,
  input  logic                                     i_rsp_err,
  input  logic [MOD_BITS-1:0]                      i_rsp_mod,
  input  logic [CTL_BITS-1:0]                      i_rsp_ctl,

  output logic                                     o_rsp_val,
  input  logic                                     o_rsp_rdy,
  output logic [DAT_BITS-1:0]                      o_rsp_dat,
  output logic                                     o_rsp_sop,
  output logic                                     o_rsp_eop,
  output logic                                     o_rsp_err,
  output logic [MOD_BITS-1:0]                      o_rsp_mod,
  output logic [CTL_BITS-1:0]                      o_rsp_ctl,

  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     o_outstanding,
  output logic                                     o_timeout
);

  localparam int PTR_BITS = $clog2(MAX_OUTSTANDING);
  localparam int CNT_BITS = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'(MAX_OUTSTANDING);

  if ((MAX_OUTSTANDING < 2) || (MAX_OUTSTANDING > 256) ||
      ((MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0) || (TIMEOUT_CYC < 1)) begin : g_bad_param
    $error("resource_tag_track_bp: MAX_OUTSTANDING must be a power of two in 2..256, TIMEOUT_CYC >= 1");
  end

  logic [CTL_BITS-1:0] tag_mem [MAX_OUTSTANDING];
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;
  logic [CNT_BITS-1:0] count;
  logic                blk;
  logic                not_empty;
  logic                push;
  logic                pop;

  // The resource ignores ctl on its response; the tag comes from the FIFO.
  logic unused_rsp_ctl;
  assign unused_rsp_ctl = ^i_rsp_ctl;

  // Blocking looks at the registered count only, so a same-cycle pop does not
  // free a slot until the next cycle. This keeps val independent of rdy.
  assign blk       = i_req_sop && (count == CNT_FULL);
  assign not_empty = (count != '0);

  assign o_req_val = i_req_val && !blk;
  assign i_req_rdy = o_req_rdy && !blk;
  assign o_req_dat = i_req_dat;
  assign o_req_sop = i_req_sop;
  assign o_req_eop = i_req_eop;
  assign o_req_err = i_req_err;
  assign o_req_mod = i_req_mod;
  assign o_req_ctl = i_req_ctl;

  // An empty FIFO holds the resource off rather than dropping its response.
  assign o_rsp_val = i_rsp_val && not_empty;
  assign i_rsp_rdy = o_rsp_rdy && not_empty;
  assign o_rsp_dat = i_rsp_dat;
  assign o_rsp_sop = i_rsp_sop;
  assign o_rsp_eop = i_rsp_eop;
  assign o_rsp_err = i_rsp_err;
  assign o_rsp_mod = i_rsp_mod;
  assign o_rsp_ctl = tag_mem[rd_ptr];

  assign push = i_req_val && i_req_rdy && i_req_sop;
  assign pop  = i_rsp_val && i_rsp_rdy && i_rsp_eop;

  always_ff @(posedge i_clk) begin
    if (push) begin
      tag_mem[wr_ptr] <= i_req_ctl;
    end
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_BITS'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_BITS'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_BITS'(1);
        2'b01:   count <= count - CNT_BITS'(1);
        default: count <= count;
      endcase
    end
  end

  assign o_outstanding = count;

`ifdef RESOURCE_TAG_TIMEOUT_EN
  localparam int WD_BITS = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_BITS-1:0] WD_LIMIT = WD_BITS'(TIMEOUT_CYC);

  logic [WD_BITS-1:0] wd_cnt;
  logic [WD_BITS-1:0] wd_next;
  logic               timeout_q;

  // Counts cycles since the last pop while tags are outstanding; saturates.
  always_comb begin
    wd_next = wd_cnt;
    if (pop || !not_empty) begin
      wd_next = '0;
    end else if (wd_cnt != WD_LIMIT) begin
      wd_next = wd_cnt + WD_BITS'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt <= wd_next;
      if (wd_next == WD_LIMIT) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_resource_tag_track_bp.sv
module tb_resource_tag_track_bp;

  localparam int CTL_BITS = 16;
  localparam int DAT_BYTS = 8;
  localparam int DAT_BITS = 64;
  localparam int MOD_BITS = 3;
  localparam int MAXO     = 8;
  localparam int NPKT     = 1000;

`ifdef RESOURCE_TAG_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  logic                i_clk = 1'b0;
  logic                i_rst_n;
  logic                i_req_val, i_req_rdy, i_req_sop, i_req_eop, i_req_err;
  logic [DAT_BITS-1:0] i_req_dat;
  logic [MOD_BITS-1:0] i_req_mod;
  logic [CTL_BITS-1:0] i_req_ctl;
  logic                o_req_val, o_req_rdy, o_req_sop, o_req_eop, o_req_err;
  logic [DAT_BITS-1:0] o_req_dat;
  logic [MOD_BITS-1:0] o_req_mod;
  logic [CTL_BITS-1:0] o_req_ctl;
  logic                i_rsp_val, i_rsp_rdy, i_rsp_sop, i_rsp_eop, i_rsp_err;
  logic [DAT_BITS-1:0] i_rsp_dat;
  logic [MOD_BITS-1:0] i_rsp_mod;
  logic [CTL_BITS-1:0] i_rsp_ctl;
  logic                o_rsp_val, o_rsp_rdy, o_rsp_sop, o_rsp_eop, o_rsp_err;
  logic [DAT_BITS-1:0] o_rsp_dat;
  logic [MOD_BITS-1:0] o_rsp_mod;
  logic [CTL_BITS-1:0] o_rsp_ctl;
  logic [3:0]          o_outstanding;
  logic                o_timeout;

  int tests = 0;
  int fails = 0;

  always #5 i_clk = ~i_clk;

  resource_tag_track_bp #(
    .CTL_BITS(CTL_BITS), .DAT_BYTS(DAT_BYTS), .DAT_BITS(DAT_BITS), .MOD_BITS(MOD_BITS),
    .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYC(16)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_val(i_req_val), .i_req_rdy(i_req_rdy), .i_req_dat(i_req_dat), .i_req_sop(i_req_sop),
    .i_req_eop(i_req_eop), .i_req_err(i_req_err), .i_req_mod(i_req_mod), .i_req_ctl(i_req_ctl),
    .o_req_val(o_req_val), .o_req_rdy(o_req_rdy), .o_req_dat(o_req_dat), .o_req_sop(o_req_sop),
    .o_req_eop(o_req_eop), .o_req_err(o_req_err), .o_req_mod(o_req_mod), .o_req_ctl(o_req_ctl),
    .i_rsp_val(i_rsp_val), .i_rsp_rdy(i_rsp_rdy), .i_rsp_dat(i_rsp_dat), .i_rsp_sop(i_rsp_sop),
    .i_rsp_eop(i_rsp_eop), .i_rsp_err(i_rsp_err), .i_rsp_mod(i_rsp_mod), .i_rsp_ctl(i_rsp_ctl),
    .o_rsp_val(o_rsp_val), .o_rsp_rdy(o_rsp_rdy), .o_rsp_dat(o_rsp_dat), .o_rsp_sop(o_rsp_sop),
    .o_rsp_eop(o_rsp_eop), .o_rsp_err(o_rsp_err), .o_rsp_mod(o_rsp_mod), .o_rsp_ctl(o_rsp_ctl),
    .o_outstanding(o_outstanding), .o_timeout(o_timeout)
  );

  typedef struct {
    string       name;
    logic        qv, qs, qe;
    logic [15:0] qc;
    logic        dn;
    logic        sv, ss, se;
    logic        up;
    logic        e_qv, e_qr, e_sv, e_sr;
    logic [15:0] e_ctl;
    logic        ck;
    int          e_out;
  } vec_t;

  function automatic vec_t v(input string n, input logic qv, qs, qe, input logic [15:0] qc,
                             input logic dn, input logic sv, ss, se, input logic up,
                             input logic e_qv, e_qr, e_sv, e_sr, input logic [15:0] e_ctl,
                             input logic ck, input int e_out);
    vec_t r;
    r.name = n; r.qv = qv; r.qs = qs; r.qe = qe; r.qc = qc; r.dn = dn;
    r.sv = sv; r.ss = ss; r.se = se; r.up = up;
    r.e_qv = e_qv; r.e_qr = e_qr; r.e_sv = e_sv; r.e_sr = e_sr;
    r.e_ctl = e_ctl; r.ck = ck; r.e_out = e_out;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic idle();
    i_req_val = 1'b0; i_req_sop = 1'b0; i_req_eop = 1'b0; i_req_ctl = '0;
    i_rsp_val = 1'b0; i_rsp_sop = 1'b0; i_rsp_eop = 1'b0;
    o_req_rdy = 1'b1; o_rsp_rdy = 1'b0;
  endtask

  // Applies one vector just after a rising edge, checks mid-cycle, then clocks.
  task automatic step(input vec_t t);
    i_req_val = t.qv; i_req_sop = t.qs; i_req_eop = t.qe; i_req_ctl = t.qc;
    i_req_dat = {$urandom, $urandom}; i_req_err = 1'b0; i_req_mod = 3'(t.qc);
    o_req_rdy = t.dn;
    i_rsp_val = t.sv; i_rsp_sop = t.ss; i_rsp_eop = t.se; i_rsp_ctl = 16'hFFFF;
    i_rsp_dat = {$urandom, $urandom}; i_rsp_err = 1'b0; i_rsp_mod = '0;
    o_rsp_rdy = t.up;
    #2;
    check({t.name, " o_req.val"}, 64'(o_req_val), 64'(t.e_qv));
    check({t.name, " i_req.rdy"}, 64'(i_req_rdy), 64'(t.e_qr));
    check({t.name, " o_rsp.val"}, 64'(o_rsp_val), 64'(t.e_sv));
    check({t.name, " i_rsp.rdy"}, 64'(i_rsp_rdy), 64'(t.e_sr));
    check({t.name, " outstanding"}, 64'(o_outstanding), 64'(t.e_out));
    if (t.ck) check({t.name, " o_rsp.ctl"}, 64'(o_rsp_ctl), 64'(t.e_ctl));
    check({t.name, " o_req.dat"}, o_req_dat, i_req_dat);
    check({t.name, " o_rsp.dat"}, o_rsp_dat, i_rsp_dat);
    @(posedge i_clk);
    #1;
  endtask

  vec_t vecs[$];

  // Random test state: reference model is a queue of expected tags plus a
  // queue of pending response lengths owned by the emulated resource.
  logic [15:0] exp_q[$];
  int          rsp_len_q[$];
  logic [15:0] cur_ctl;
  int          req_len, beat, rbeat, sent, done, cyc;
  logic        rv, sv, blk, req_x, rsp_x;

  initial begin
    vecs.push_back(v("t1_push",        1,1,1,16'h0003,1, 1,1,1,1, 1,1,0,0,16'h0000,0,0));
    vecs.push_back(v("t1_rsp",         0,0,0,16'h0000,1, 1,1,1,1, 0,1,1,1,16'h0003,1,1));
    vecs.push_back(v("t1_idle",        0,0,0,16'h0000,1, 0,0,0,1, 0,1,0,0,16'h0000,0,0));
    vecs.push_back(v("dn_stall",       1,1,1,16'h0012,0, 0,0,0,1, 1,0,0,0,16'h0000,0,0));
    vecs.push_back(v("t3_req_b0",      1,1,0,16'h0012,1, 0,0,0,1, 1,1,0,0,16'h0000,0,0));
    vecs.push_back(v("t3_req_b1",      1,0,0,16'h0099,1, 0,0,0,0, 1,1,0,0,16'h0000,0,1));
    vecs.push_back(v("t3_req_b2",      1,0,1,16'h0077,1, 1,1,0,0, 1,1,1,0,16'h0012,1,1));
    vecs.push_back(v("t3_rsp_b0",      0,0,0,16'h0000,1, 1,1,0,1, 0,1,1,1,16'h0012,1,1));
    vecs.push_back(v("t3_rsp_b1_hold", 0,0,0,16'h0000,1, 1,0,0,0, 0,1,1,0,16'h0012,1,1));
    vecs.push_back(v("t3_rsp_b1",      0,0,0,16'h0000,1, 1,0,0,1, 0,1,1,1,16'h0012,1,1));
    vecs.push_back(v("t3_rsp_b2",      0,0,0,16'h0000,1, 1,0,0,1, 0,1,1,1,16'h0012,1,1));
    vecs.push_back(v("t3_rsp_b3_hold", 0,0,0,16'h0000,1, 1,0,1,0, 0,1,1,0,16'h0012,1,1));
    vecs.push_back(v("t3_rsp_b3",      0,0,0,16'h0000,1, 1,0,1,1, 0,1,1,1,16'h0012,1,1));
    vecs.push_back(v("t3_idle",        0,0,0,16'h0000,1, 0,0,0,1, 0,1,0,0,16'h0000,0,0));
    vecs.push_back(v("gate_empty",     0,0,0,16'h0000,1, 1,1,1,1, 0,1,0,0,16'h0000,0,0));
    vecs.push_back(v("gate_req",       1,1,1,16'h5A5A,1, 1,1,1,1, 1,1,0,0,16'h0000,0,0));
    vecs.push_back(v("gate_rsp",       0,0,0,16'h0000,1, 1,1,1,1, 0,1,1,1,16'h5A5A,1,1));
    vecs.push_back(v("gate_idle",      0,0,0,16'h0000,1, 0,0,0,1, 0,1,0,0,16'h0000,0,0));

    i_rst_n = 1'b0;
    idle();
    i_req_dat = '0; i_req_err = 1'b0; i_req_mod = '0;
    i_rsp_dat = '0; i_rsp_err = 1'b0; i_rsp_mod = '0; i_rsp_ctl = '0;
    #12;
    i_rsp_val = 1'b1; i_rsp_eop = 1'b1; o_rsp_rdy = 1'b1;
    #1;
    check("rst outstanding", 64'(o_outstanding), 64'd0);
    check("rst o_timeout", 64'(o_timeout), 64'd0);
    check("rst o_rsp.val", 64'(o_rsp_val), 64'd0);
    check("rst i_rsp.rdy", 64'(i_rsp_rdy), 64'd0);
    idle();
    #9;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    foreach (vecs[i]) step(vecs[i]);

    // Fill to depth with the resource stalled, then check the full boundary.
    for (int i = 0; i < MAXO; i++)
      step(v("full_fill", 1,1,1,16'(i),1, 0,0,0,0, 1,1,0,0,16'h0000,0,i));
    step(v("full_block",     1,1,1,16'h0008,1, 0,0,0,0, 0,0,0,0,16'h0000,0,8));
    step(v("full_nonsop",    1,0,1,16'h00AB,1, 0,0,0,0, 1,1,0,0,16'h0000,0,8));
    step(v("full_pop_block", 1,1,1,16'h0008,1, 1,1,1,1, 0,0,1,1,16'h0000,1,8));
    step(v("full_accept",    1,1,1,16'h0008,1, 0,0,0,0, 1,1,0,0,16'h0000,0,7));
    for (int k = 0; k < MAXO; k++)
      step(v("drain", 0,0,0,16'h0000,1, 1,1,1,1, 0,1,1,1,16'(k + 1),1,8 - k));
    step(v("drain_idle", 0,0,0,16'h0000,1, 0,0,0,1, 0,1,0,0,16'h0000,0,0));

    // Watchdog: one request, no response.
    step(v("to_push", 1,1,1,16'h0042,1, 0,0,0,0, 1,1,0,0,16'h0000,0,0));
    idle();
    repeat (15) @(posedge i_clk);
    #1;
    check("to_before_limit", 64'(o_timeout), 64'd0);
    @(posedge i_clk);
    #1;
    check("to_at_limit", 64'(o_timeout), 64'(TO_EN));
    step(v("to_late_rsp", 0,0,0,16'h0000,1, 1,1,1,1, 0,1,1,1,16'h0042,1,1));
    idle();
    #1;
    check("to_sticky", 64'(o_timeout), 64'(TO_EN));
    check("to_after_pop_cnt", 64'(o_outstanding), 64'd0);

    // Mid-operation reset with tags outstanding.
    step(v("rst_push", 1,1,1,16'h0777,1, 0,0,0,0, 1,1,0,0,16'h0000,0,0));
    idle();
    #3;
    i_rst_n = 1'b0;
    i_rsp_val = 1'b1; i_rsp_eop = 1'b1; o_rsp_rdy = 1'b1;
    #1;
    check("midrst outstanding", 64'(o_outstanding), 64'd0);
    check("midrst o_timeout", 64'(o_timeout), 64'd0);
    check("midrst o_rsp.val", 64'(o_rsp_val), 64'd0);
    check("midrst o_req.val", 64'(o_req_val), 64'd0);
    idle();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Random traffic against the queue model.
    cur_ctl = 16'($urandom); req_len = $urandom_range(1, 3); beat = 0; rbeat = 0;
    sent = 0; done = 0; cyc = 0;
    while (done < NPKT && cyc < 60000) begin
      cyc++;
      rv = (sent < NPKT) && ($urandom_range(0, 3) != 0);
      i_req_val = rv; i_req_sop = (beat == 0); i_req_eop = (beat == req_len - 1);
      i_req_ctl = cur_ctl; i_req_dat = {$urandom, $urandom};
      i_req_err = 1'($urandom); i_req_mod = 3'($urandom);
      o_req_rdy = ($urandom_range(0, 3) != 0);
      sv = (rsp_len_q.size() > 0) && ($urandom_range(0, 3) != 0);
      i_rsp_val = sv; i_rsp_sop = (rbeat == 0);
      i_rsp_eop = sv ? (rbeat == rsp_len_q[0] - 1) : 1'b0;
      i_rsp_ctl = 16'($urandom); i_rsp_dat = {$urandom, $urandom};
      i_rsp_err = 1'($urandom); i_rsp_mod = 3'($urandom);
      o_rsp_rdy = ($urandom_range(0, 3) != 0);
      #2;
      blk = i_req_sop && (exp_q.size() == MAXO);
      check("rnd o_req.val", 64'(o_req_val), 64'(rv && !blk));
      check("rnd i_req.rdy", 64'(i_req_rdy), 64'(o_req_rdy && !blk));
      check("rnd o_rsp.val", 64'(o_rsp_val), 64'(sv && exp_q.size() != 0));
      check("rnd i_rsp.rdy", 64'(i_rsp_rdy), 64'(o_rsp_rdy && exp_q.size() != 0));
      check("rnd outstanding", 64'(o_outstanding), 64'(exp_q.size()));
      check("rnd o_req.ctl", 64'(o_req_ctl), 64'(i_req_ctl));
      check("rnd o_rsp.pass", {o_rsp_dat[59:0], o_rsp_err, o_rsp_mod},
            {i_rsp_dat[59:0], i_rsp_err, i_rsp_mod});
      req_x = rv && o_req_rdy && !blk;
      rsp_x = sv && o_rsp_rdy && (exp_q.size() != 0);
      if (rsp_x) begin
        check("rnd o_rsp.ctl", 64'(o_rsp_ctl), 64'(exp_q[0]));
        rbeat++;
        if (i_rsp_eop) begin
          void'(exp_q.pop_front());
          void'(rsp_len_q.pop_front());
          done++;
          rbeat = 0;
        end
      end
      if (req_x) begin
        if (i_req_sop) begin
          exp_q.push_back(cur_ctl);
          rsp_len_q.push_back($urandom_range(1, 3));
        end
        beat++;
        if (i_req_eop) begin
          sent++;
          beat = 0;
          cur_ctl = 16'($urandom);
          req_len = $urandom_range(1, 3);
        end
      end
      @(posedge i_clk);
      #1;
    end
    tests++;
    if (done != NPKT) begin
      fails++;
      $display("FAIL rnd_budget: completed %0d packets, required %0d", done, NPKT);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
